uart_tx_ctrl: RTL and testbench

UART transmit controller and serializer that sits directly downstream of the TX parity stage. It accepts one parallel data word per frame and drives the serial line with start, data (LSB first), optional parity and stop bits. It returns a `free` indication to the parity stage so both blocks capture the same word on the same edge, and consumes the parity stage's `par_bit` when framing the parity slot.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_ctrl_if.sv | 34 +++
 rtl/uart_tx_serializer.sv | 35 +++
 rtl/uart_tx_ctrl.sv | 90 +++++++++
 tb/tb_uart_tx_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller.
// Frame states use a 3-bit binary encoding.
package uart_tx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam logic        LINE_IDLE          = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and line signals between the parity stage / host and the TX controller.
interface uart_tx_ctrl_if
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_bit;
    logic                  tx_out;
    logic                  busy;
    logic                  free;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_bit,
        input  tx_out,
        input  busy,
        input  free
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_bit,
        output tx_out,
        output busy,
        output free
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register (LSB first) and bit counter for one UART frame.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ser_bit,
    output logic                  o_ser_done
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Counter reaches DATA_WIDTH once the last payload bit has been placed on the line.
    assign o_ser_bit  = r_shift[0];
    assign o_ser_done = (r_cnt == CNT_W'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX framing FSM: start, LSB-first data, optional parity, stop.
// Line bit and busy are registered from the next state so they change on state entry.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);
    tx_state_e r_state;
    tx_state_e w_state_d;

    logic r_par_en;
    logic r_tx;
    logic r_busy;

    logic w_free;
    logic w_accept;
    logic w_shift;
    logic w_ser_bit;
    logic w_ser_done;
    logic w_tx_d;

    assign w_free   = (r_state == IDLE) || (r_state == STOP);
    assign w_accept = bus.data_valid && w_free;
    assign w_shift  = (w_state_d == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_shift    (w_shift),
        .i_data     (bus.p_data),
        .o_ser_bit  (w_ser_bit),
        .o_ser_done (w_ser_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_d = START;
            START:   w_state_d = DATA;
            DATA:    if (w_ser_done) w_state_d = r_par_en ? PARITY : STOP;
            PARITY:  w_state_d = STOP;
            STOP:    w_state_d = w_accept ? START : IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_tx_d = LINE_IDLE;
        case (w_state_d)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = w_ser_bit;
            PARITY:  w_tx_d = bus.par_bit;
            default: w_tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx     <= LINE_IDLE;
            r_busy   <= 1'b0;
            r_par_en <= 1'b0;
        end else begin
            r_tx   <= w_tx_d;
            r_busy <= (w_state_d != IDLE);
            if (w_accept) begin
                r_par_en <= bus.par_en;
            end
        end
    end

    assign bus.tx_out = r_tx;
    assign bus.busy   = r_busy;
    assign bus.free   = w_free;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frames are predicted as bit lists built from the
// word, parity enable and parity bit, and compared cycle by cycle with the line.
module tb_uart_tx_ctrl;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Behavioural parity stage: captures parity of the word on the same accept edge.
    logic tb_par_bit  = 1'b0;
    logic use_stage   = 1'b0;
    logic parity_type = 1'b1;
    logic stage_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_par <= 1'b0;
        else if (bus.data_valid && bus.free)
            stage_par <= parity_type ? (^bus.p_data) : ~(^bus.p_data);
    end

    assign bus.par_bit = use_stage ? stage_par : tb_par_bit;

    logic [DW-1:0] q_data[$];
    logic          q_pe[$];
    logic          q_pb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pb);
        q_data.push_back(d);
        q_pe.push_back(pe);
        q_pb.push_back(pb);
    endtask

    // Sends the queued frames back-to-back, scrambling ignored inputs mid-frame.
    task automatic run_stream(input bit hold_valid, input string name);
        logic          exp_tx[$];
        logic          exp_free[$];
        logic [DW-1:0] w;
        int unsigned   f;
        int unsigned   n;
        n = q_data.size();
        for (int unsigned k = 0; k < n; k++) begin
            w = q_data[k];
            exp_tx.push_back(1'b0); exp_free.push_back(1'b0);
            for (int unsigned i = 0; i < DW; i++) begin
                exp_tx.push_back(w[i]); exp_free.push_back(1'b0);
            end
            if (q_pe[k]) begin
                exp_tx.push_back(q_pb[k]); exp_free.push_back(1'b0);
            end
            exp_tx.push_back(1'b1); exp_free.push_back(1'b1);
        end
        f = 0;
        bus.p_data     = q_data[0];
        bus.par_en     = q_pe[0];
        tb_par_bit     = q_pb[0];
        bus.data_valid = 1'b1;
        for (int unsigned c = 0; c < exp_tx.size(); c++) begin
            @(posedge clk); #1;
            chk($sformatf("%s c%0d tx", name, c), 32'(bus.tx_out), 32'(exp_tx[c]));
            chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'd1);
            chk($sformatf("%s c%0d free", name, c), 32'(bus.free), 32'(exp_free[c]));
            if (exp_free[c]) begin
                if (f + 1 < n) begin
                    f++;
                    bus.p_data     = q_data[f];
                    bus.par_en     = q_pe[f];
                    tb_par_bit     = q_pb[f];
                    bus.data_valid = 1'b1;
                end else begin
                    bus.data_valid = 1'b0;
                end
            end else begin
                bus.data_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
                bus.p_data     = DW'($urandom);
                bus.par_en     = 1'($urandom_range(0, 1));
            end
        end
        for (int unsigned c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("%s idle%0d tx", name, c), 32'(bus.tx_out), 32'd1);
            chk($sformatf("%s idle%0d busy", name, c), 32'(bus.busy), 32'd0);
            chk($sformatf("%s idle%0d free", name, c), 32'(bus.free), 32'd1);
        end
        q_data.delete();
        q_pe.delete();
        q_pb.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] w;
        logic          pe;
        int unsigned   nf;

        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("reset tx", 32'(bus.tx_out), 32'd1);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset free", 32'(bus.free), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        push_frame(8'h5A, 1'b0, 1'b0);
        run_stream(1'b0, "nopar_5A");

        push_frame(8'hA5, 1'b1, 1'b0);
        run_stream(1'b0, "par0_A5");

        push_frame(8'hA5, 1'b1, 1'b1);
        run_stream(1'b0, "par1_A5");

        push_frame(8'h01, 1'b0, 1'b0);
        push_frame(8'h80, 1'b0, 1'b0);
        run_stream(1'b1, "b2b");

        push_frame(8'h3C, 1'b0, 1'b0);
        run_stream(1'b0, "midframe_3C");

        // Reset asserted while data bit 3 is on the line.
        d = DW'($urandom);
        bus.p_data     = d;
        bus.par_en     = 1'b0;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_pre bit3", 32'(bus.tx_out), 32'(d[3]));
        #2 rst = 1'b0;
        #1;
        chk("rst_async tx", 32'(bus.tx_out), 32'd1);
        chk("rst_async busy", 32'(bus.busy), 32'd0);
        chk("rst_async free", 32'(bus.free), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        push_frame(8'hFF, 1'b1, 1'($urandom_range(0, 1)));
        run_stream(1'b0, "post_rst_FF");

        // Parity supplied by the behavioural parity stage.
        use_stage   = 1'b1;
        parity_type = 1'b1;
        w = 8'h07;
        push_frame(w, 1'b1, ^w);
        run_stream(1'b0, "stage_07");
        for (int unsigned t = 0; t < 3; t++) begin
            parity_type = 1'($urandom_range(0, 1));
            for (int unsigned k = 0; k < 2; k++) begin
                w = DW'($urandom);
                push_frame(w, 1'b1, parity_type ? (^w) : ~(^w));
            end
            run_stream(1'($urandom_range(0, 1)), $sformatf("stage_rand%0d", t));
        end
        use_stage = 1'b0;

        for (int unsigned t = 0; t < 8; t++) begin
            nf = $urandom_range(1, 3);
            for (int unsigned k = 0; k < nf; k++) begin
                pe = 1'($urandom_range(0, 1));
                push_frame(DW'($urandom), pe, 1'($urandom_range(0, 1)));
            end
            run_stream(1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
